// File: rtl/inst_fetch_bus_if.sv
// Instruction bus bundle: classic single-beat cyc/stb/ack read channel.
// Latency: none, wires only.
// Backpressure: the responder stretches a read by holding bus_ack_i low.
interface inst_fetch_bus_if;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;

  // Fetch unit side: drives the request, samples ack/data.
  modport master (
    output bus_cyc_o, bus_stb_o, bus_addr_o,
    input  bus_ack_i, bus_data_i
  );

  // Memory side: samples the request, returns ack/data.
  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_addr_o,
    output bus_ack_i, bus_data_i
  );
endinterface

// File: rtl/inst_fetch_bus.sv
// Fetch responder: one single-beat bus read per PC, word returned to IF/ID.
// Latency: issue edge E0, ack sampled E1, delivery pulse after E1; 1 instr / 3 cycles peak.
// Backpressure: stall parks acked data in a hold buffer; the bus waits via ack; flush drops the fetch.
module inst_fetch_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [31:0]      pc,
  input  logic             stall,
  input  logic             flush,
  output logic             pc_read_ready,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_pc_o,
  output logic             inst_valid_o,
  output logic             fetch_err_o,
  inst_fetch_bus_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

  // Counter value at which a request without ack is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_nxt;
  logic        cyc_q, cyc_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] ipc_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic [7:0]  cnt_q, cnt_nxt;
  logic        rdy_nxt;
  logic        err_nxt;

  // Bus outputs come straight from flops; stb mirrors cyc.
  assign bus.bus_cyc_o  = cyc_q;
  assign bus.bus_stb_o  = cyc_q;
  assign bus.bus_addr_o = addr_q;

  // Next-state and next-output selection for the fetch FSM.
  always_comb begin
    state_nxt = state_q;
    cyc_nxt   = cyc_q;
    addr_nxt  = addr_q;
    ipc_nxt   = inst_pc_o;
    inst_nxt  = inst_o;
    hold_nxt  = hold_q;
    cnt_nxt   = cnt_q;
    rdy_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        // Skip the cycle where the ready pulse is visible: pc is moving then.
        if (ce && !flush && !pc_read_ready) begin
          addr_nxt  = {pc[31:2], 2'b00};
          ipc_nxt   = pc;
          cyc_nxt   = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (flush && bus.bus_ack_i) begin
          cyc_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (flush) begin
          // The bus cannot abort; keep cyc up and swallow the ack later.
          if (cnt_q == CNT_LAST) begin
            cyc_nxt   = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt_q + 8'd1;
            state_nxt = DRAIN;
          end
        end else if (bus.bus_ack_i && !stall) begin
          cyc_nxt   = 1'b0;
          inst_nxt  = bus.bus_data_i;
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (bus.bus_ack_i) begin
          cyc_nxt   = 1'b0;
          hold_nxt  = bus.bus_data_i;
          state_nxt = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          cyc_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (!stall) begin
          inst_nxt  = hold_q;
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (bus.bus_ack_i || (cnt_q == CNT_LAST)) begin
          cyc_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cyc_q         <= 1'b0;
      addr_q        <= 32'd0;
      inst_pc_o     <= 32'd0;
      inst_o        <= 32'd0;
      hold_q        <= 32'd0;
      cnt_q         <= 8'd0;
      pc_read_ready <= 1'b0;
      inst_valid_o  <= 1'b0;
      fetch_err_o   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cyc_q         <= cyc_nxt;
      addr_q        <= addr_nxt;
      inst_pc_o     <= ipc_nxt;
      inst_o        <= inst_nxt;
      hold_q        <= hold_nxt;
      cnt_q         <= cnt_nxt;
      pc_read_ready <= rdy_nxt;
      inst_valid_o  <= rdy_nxt;
      fetch_err_o   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bus.sv
// Bench for inst_fetch_bus: directed scenarios plus randomized run against a timing model.
// Latency: inputs driven 1ns after posedge, outputs sampled at the same point.
// Backpressure: a memory responder inserts programmable wait states on ack.
module tb_inst_fetch_bus;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        pc_read_ready, inst_valid_o, fetch_err_o;
  logic [31:0] inst_o, inst_pc_o;

  int n_checks = 0;
  int n_errs = 0;

  // Responder controls
  bit          resp_auto = 1'b1;
  bit          resp_fixed = 1'b1;
  logic [31:0] resp_data = 32'd0;
  int          next_wait = 0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = 32'd0;

  inst_fetch_bus_if bus_if ();

  inst_fetch_bus #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .stall(stall), .flush(flush),
    .pc_read_ready(pc_read_ready), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .fetch_err_o(fetch_err_o), .bus(bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // Memory responder: acks after next_wait idle cycles of cyc, one-cycle ack.
  initial begin
    int rcnt, rwait;
    bit rgave;
    rcnt = 0; rwait = 0; rgave = 1'b0;
    bus_if.bus_ack_i  = 1'b0;
    bus_if.bus_data_i = 32'd0;
    forever begin
      @(negedge clk);
      if (!resp_auto) begin
        rcnt = 0; rgave = 1'b0;
        bus_if.bus_ack_i  = man_ack;
        bus_if.bus_data_i = man_data;
      end else if (bus_if.bus_cyc_o && !rgave) begin
        if (rcnt == 0) rwait = next_wait;
        if (rcnt == rwait) begin
          bus_if.bus_ack_i  = 1'b1;
          bus_if.bus_data_i = resp_fixed ? resp_data : mem_word(bus_if.bus_addr_o);
          rgave = 1'b1;
        end else begin
          bus_if.bus_ack_i = 1'b0;
          rcnt++;
        end
      end else begin
        bus_if.bus_ack_i = 1'b0;
        if (!bus_if.bus_cyc_o) begin rcnt = 0; rgave = 1'b0; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL reset_rdy: got %b want 0", pc_read_ready); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_errs++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    n_checks++; if (fetch_err_o !== 1'b0) begin n_errs++; $display("FAIL reset_err: got %b want 0", fetch_err_o); end
    n_checks++; if (inst_o !== 32'd0) begin n_errs++; $display("FAIL reset_inst: got %h want 0", inst_o); end
    n_checks++; if (inst_pc_o !== 32'd0) begin n_errs++; $display("FAIL reset_ipc: got %h want 0", inst_pc_o); end
    n_checks++; if (bus_if.bus_cyc_o !== 1'b0) begin n_errs++; $display("FAIL reset_cyc: got %b want 0", bus_if.bus_cyc_o); end
    n_checks++; if (bus_if.bus_addr_o !== 32'd0) begin n_errs++; $display("FAIL reset_addr: got %h want 0", bus_if.bus_addr_o); end
  endtask

  task automatic test_basic();
    resp_fixed = 1'b1; resp_data = 32'h2401_0001; next_wait = 0;
    pc = 32'hbfc0_0000; ce = 1'b1; rst = 1'b0;
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL basic_cyc: got %b want 1", bus_if.bus_cyc_o); end
    n_checks++; if (bus_if.bus_stb_o !== 1'b1) begin n_errs++; $display("FAIL basic_stb: got %b want 1", bus_if.bus_stb_o); end
    n_checks++; if (bus_if.bus_addr_o !== 32'hbfc0_0000) begin n_errs++; $display("FAIL basic_addr: got %h want bfc00000", bus_if.bus_addr_o); end
    tick();
    n_checks++; if (pc_read_ready !== 1'b1) begin n_errs++; $display("FAIL basic_rdy: got %b want 1", pc_read_ready); end
    n_checks++; if (inst_valid_o !== 1'b1) begin n_errs++; $display("FAIL basic_valid: got %b want 1", inst_valid_o); end
    n_checks++; if (inst_o !== 32'h2401_0001) begin n_errs++; $display("FAIL basic_inst: got %h want 24010001", inst_o); end
    n_checks++; if (inst_pc_o !== 32'hbfc0_0000) begin n_errs++; $display("FAIL basic_ipc: got %h want bfc00000", inst_pc_o); end
    n_checks++; if (bus_if.bus_cyc_o !== 1'b0) begin n_errs++; $display("FAIL basic_cyc_drop: got %b want 0", bus_if.bus_cyc_o); end
    pc = 32'hbfc0_0004; resp_data = 32'h2402_0002;
    tick();
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL basic_rdy_single: got %b want 0", pc_read_ready); end
    n_checks++; if (bus_if.bus_cyc_o !== 1'b0) begin n_errs++; $display("FAIL basic_no_issue_on_rdy: got %b want 0", bus_if.bus_cyc_o); end
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL basic_reissue_cyc: got %b want 1", bus_if.bus_cyc_o); end
    n_checks++; if (bus_if.bus_addr_o !== 32'hbfc0_0004) begin n_errs++; $display("FAIL basic_reissue_addr: got %h want bfc00004", bus_if.bus_addr_o); end
    ce = 1'b0;
    tick();
    n_checks++; if (inst_o !== 32'h2402_0002) begin n_errs++; $display("FAIL basic_inst2: got %h want 24020002", inst_o); end
    n_checks++; if (inst_pc_o !== 32'hbfc0_0004) begin n_errs++; $display("FAIL basic_ipc2: got %h want bfc00004", inst_pc_o); end
    tick();
  endtask

  task automatic test_wait_stall();
    resp_data = 32'h8c22_0004; next_wait = 3; pc = 32'h0040_0010; ce = 1'b1;
    tick();
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL ws_cyc_wait%0d: got %b want 1", i, bus_if.bus_cyc_o); end
    end
    stall = 1'b1;
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL ws_cyc_pre_ack: got %b want 1", bus_if.bus_cyc_o); end
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b0) begin n_errs++; $display("FAIL ws_cyc_on_ack: got %b want 0", bus_if.bus_cyc_o); end
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL ws_rdy_stalled: got %b want 0", pc_read_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL ws_rdy_hold%0d: got %b want 0", i, pc_read_ready); end
    end
    stall = 1'b0;
    tick();
    n_checks++; if (pc_read_ready !== 1'b1) begin n_errs++; $display("FAIL ws_rdy: got %b want 1", pc_read_ready); end
    n_checks++; if (inst_o !== 32'h8c22_0004) begin n_errs++; $display("FAIL ws_inst: got %h want 8c220004", inst_o); end
    tick();
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL ws_rdy_single: got %b want 0", pc_read_ready); end
  endtask

  task automatic test_flush_busy();
    resp_data = 32'hdead_beef; next_wait = 2; pc = 32'h0040_0020; ce = 1'b1;
    tick();
    flush = 1'b1; pc = 32'h8000_0180;
    tick();
    flush = 1'b0;
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL fb_cyc_flush: got %b want 1", bus_if.bus_cyc_o); end
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL fb_cyc_drain: got %b want 1", bus_if.bus_cyc_o); end
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b0) begin n_errs++; $display("FAIL fb_cyc_after_ack: got %b want 0", bus_if.bus_cyc_o); end
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL fb_rdy: got %b want 0", pc_read_ready); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_errs++; $display("FAIL fb_valid: got %b want 0", inst_valid_o); end
    n_checks++; if (inst_o !== 32'h8c22_0004) begin n_errs++; $display("FAIL fb_inst_kept: got %h want 8c220004", inst_o); end
    next_wait = 0; resp_data = 32'h3c1a_8000;
    tick();
    n_checks++; if (bus_if.bus_addr_o !== 32'h8000_0180) begin n_errs++; $display("FAIL fb_next_addr: got %h want 80000180", bus_if.bus_addr_o); end
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL fb_next_cyc: got %b want 1", bus_if.bus_cyc_o); end
    ce = 1'b0;
    tick();
    n_checks++; if (inst_o !== 32'h3c1a_8000) begin n_errs++; $display("FAIL fb_next_inst: got %h want 3c1a8000", inst_o); end
    tick();
  endtask

  task automatic test_flush_hold();
    resp_data = 32'h1111_2222; next_wait = 0; pc = 32'h0040_0030; ce = 1'b1; stall = 1'b1;
    tick();
    ce = 1'b0;
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL fh_issue_under_stall: got %b want 1", bus_if.bus_cyc_o); end
    tick();
    flush = 1'b1;
    tick();
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL fh_rdy_flush: got %b want 0", pc_read_ready); end
    flush = 1'b0; stall = 1'b0; ce = 1'b1; pc = 32'h0040_0040; resp_data = 32'h3333_4444;
    tick();
    ce = 1'b0;
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL fh_no_delivery: got %b want 0", pc_read_ready); end
    n_checks++; if (inst_o !== 32'h3c1a_8000) begin n_errs++; $display("FAIL fh_inst_kept: got %h want 3c1a8000", inst_o); end
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL fh_idle_reissue: got %b want 1", bus_if.bus_cyc_o); end
    tick();
    n_checks++; if (inst_o !== 32'h3333_4444) begin n_errs++; $display("FAIL fh_next_inst: got %h want 33334444", inst_o); end
    tick();
  endtask

  task automatic test_timeout();
    next_wait = 99; pc = 32'h0040_0050; ce = 1'b1;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL to_cyc%0d: got %b want 1", i, bus_if.bus_cyc_o); end
      n_checks++; if (fetch_err_o !== 1'b0) begin n_errs++; $display("FAIL to_err_early%0d: got %b want 0", i, fetch_err_o); end
    end
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b0) begin n_errs++; $display("FAIL to_cyc_drop: got %b want 0", bus_if.bus_cyc_o); end
    n_checks++; if (fetch_err_o !== 1'b1) begin n_errs++; $display("FAIL to_err: got %b want 1", fetch_err_o); end
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL to_rdy: got %b want 0", pc_read_ready); end
    next_wait = 0; resp_data = 32'h5555_6666;
    tick();
    n_checks++; if (fetch_err_o !== 1'b0) begin n_errs++; $display("FAIL to_err_single: got %b want 0", fetch_err_o); end
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL to_retry_cyc: got %b want 1", bus_if.bus_cyc_o); end
    n_checks++; if (bus_if.bus_addr_o !== 32'h0040_0050) begin n_errs++; $display("FAIL to_retry_addr: got %h want 00400050", bus_if.bus_addr_o); end
    ce = 1'b0;
    tick();
    n_checks++; if (inst_o !== 32'h5555_6666) begin n_errs++; $display("FAIL to_retry_inst: got %h want 55556666", inst_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    resp_auto = 1'b0; man_ack = 1'b0; pc = 32'h0040_0060; ce = 1'b1;
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b1) begin n_errs++; $display("FAIL rm_cyc: got %b want 1", bus_if.bus_cyc_o); end
    rst = 1'b1; ce = 1'b0;
    tick();
    n_checks++; if (bus_if.bus_cyc_o !== 1'b0) begin n_errs++; $display("FAIL rm_cyc_rst: got %b want 0", bus_if.bus_cyc_o); end
    n_checks++; if (bus_if.bus_addr_o !== 32'd0) begin n_errs++; $display("FAIL rm_addr_rst: got %h want 0", bus_if.bus_addr_o); end
    n_checks++; if (inst_o !== 32'd0) begin n_errs++; $display("FAIL rm_inst_rst: got %h want 0", inst_o); end
    n_checks++; if (inst_pc_o !== 32'd0) begin n_errs++; $display("FAIL rm_ipc_rst: got %h want 0", inst_pc_o); end
    rst = 1'b0; man_ack = 1'b1; man_data = 32'h1234_5678;
    tick();
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL rm_late_ack_rdy: got %b want 0", pc_read_ready); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_errs++; $display("FAIL rm_late_ack_valid: got %b want 0", inst_valid_o); end
    man_ack = 1'b0;
    tick();
    n_checks++; if (pc_read_ready !== 1'b0) begin n_errs++; $display("FAIL rm_late_rdy2: got %b want 0", pc_read_ready); end
    n_checks++; if (inst_o !== 32'd0) begin n_errs++; $display("FAIL rm_late_inst: got %h want 0", inst_o); end
    resp_auto = 1'b1;
  endtask

  // Randomized run: the model tracks each request by its age in cycles and the
  // wait it was given, and predicts delivery at the first unstalled edge after ack.
  task automatic test_random();
    bit m_busy, m_have, m_rdy_prev, exp_rdy, exp_err;
    int m_age, m_w;
    logic [31:0] m_addr, m_data, exp_inst, exp_ipc;
    rst = 1'b1; ce = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0; resp_fixed = 1'b0; next_wait = $urandom_range(0, 5);
    m_busy = 0; m_have = 0; m_rdy_prev = 0; m_age = 0; m_w = 0;
    m_addr = 0; m_data = 0; exp_inst = 0; exp_ipc = 0;
    for (int it = 0; it < 600; it++) begin
      tick();
      exp_rdy = 0; exp_err = 0;
      if (m_busy) begin
        m_age++;
        if (m_w < TO && m_age == m_w + 1) begin
          m_busy = 0; m_have = 1; m_data = mem_word(m_addr);
        end else if (m_w >= TO && m_age == TO) begin
          m_busy = 0; exp_err = 1;
        end
      end else if (!m_have && ce && !m_rdy_prev) begin
        m_busy = 1; m_age = 0; m_w = next_wait;
        m_addr = {pc[31:2], 2'b00}; exp_ipc = pc;
      end
      if (m_have && !stall) begin
        exp_rdy = 1; m_have = 0; exp_inst = m_data;
      end
      m_rdy_prev = exp_rdy;
      n_checks++; if (bus_if.bus_cyc_o !== m_busy) begin n_errs++; $display("FAIL rnd_cyc@%0d: got %b want %b", it, bus_if.bus_cyc_o, m_busy); end
      n_checks++; if (bus_if.bus_stb_o !== m_busy) begin n_errs++; $display("FAIL rnd_stb@%0d: got %b want %b", it, bus_if.bus_stb_o, m_busy); end
      n_checks++; if (pc_read_ready !== exp_rdy) begin n_errs++; $display("FAIL rnd_rdy@%0d: got %b want %b", it, pc_read_ready, exp_rdy); end
      n_checks++; if (inst_valid_o !== exp_rdy) begin n_errs++; $display("FAIL rnd_valid@%0d: got %b want %b", it, inst_valid_o, exp_rdy); end
      n_checks++; if (fetch_err_o !== exp_err) begin n_errs++; $display("FAIL rnd_err@%0d: got %b want %b", it, fetch_err_o, exp_err); end
      n_checks++; if (inst_o !== exp_inst) begin n_errs++; $display("FAIL rnd_inst@%0d: got %h want %h", it, inst_o, exp_inst); end
      n_checks++; if (inst_pc_o !== exp_ipc) begin n_errs++; $display("FAIL rnd_ipc@%0d: got %h want %h", it, inst_pc_o, exp_ipc); end
      if (m_busy) begin
        n_checks++; if (bus_if.bus_addr_o !== m_addr) begin n_errs++; $display("FAIL rnd_addr@%0d: got %h want %h", it, bus_if.bus_addr_o, m_addr); end
      end
      ce = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 2) == 0);
      pc = $urandom;
      if (!m_busy) next_wait = $urandom_range(0, 5);
    end
    ce = 1'b0; stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wait_stall();
    test_flush_busy();
    test_flush_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
